// File: rtl/pulse_event_arbiter_if.sv
// Event stream interface between the pulse event arbiter and its consumer
// (event logger / interrupt block).
//   evt_valid : an event is presented (driven by master)
//   evt_ch    : channel ID of the presented event (driven by master)
//   evt_ready : consumer accepts the event (driven by slave)
// A transfer happens on a rising clock edge with evt_valid=1 and evt_ready=1.
interface pulse_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_ch;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );
endinterface

// File: rtl/pulse_event_arbiter.sv
// Pulse event arbiter: collects one-cycle pulses from NUM_CH pulse detectors,
// keeps a saturating pending count per channel and serialises them as
// channel-ID events onto a single valid/ready stream. Channels share the
// stream through round-robin arbitration.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   pulse_in     one-cycle pulse flags, one bit per channel
//   ch_enable    per-channel enable; low ignores pulses and clears the count
//   evt          event stream (master side: evt_valid, evt_ch out; evt_ready in)
//   pending_any  some channel has a non-zero pending count (from registers only)
//   drop_pulse   registered; high one cycle after a pulse was lost to saturation
//   ovf_clr      (PULSE_ARB_OVF_STICKY_EN only) per-channel sticky clear
//   ovf_sticky   (PULSE_ARB_OVF_STICKY_EN only) per-channel sticky overflow flag
//
// Optional feature macro: PULSE_ARB_OVF_STICKY_EN. When undefined the sticky
// ports do not exist and saturation is reported via drop_pulse only.
module pulse_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pulse_in,
    input  logic [NUM_CH-1:0] ch_enable,
`ifdef PULSE_ARB_OVF_STICKY_EN
    input  logic [NUM_CH-1:0] ovf_clr,
    output logic [NUM_CH-1:0] ovf_sticky,
`endif
    pulse_event_arbiter_if.master evt,
    output logic              pending_any,
    output logic              drop_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ch_q, ch_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               load;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  inc, dec, lost, nz;
    logic [2*NUM_CH-1:0] nz_rot;
    logic [ID_W:0]      start;

    // Saturating counter step; returns {lost, next_count}. A simultaneous
    // increment and decrement cancel, so no pulse is lost even at max.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc_i,
                                                input logic dec_i);
        logic [CNT_W:0] res;
        res = {1'b0, cnt};
        if (inc_i && !dec_i) begin
            if (cnt == CNT_MAX) res[CNT_W] = 1'b1;
            else                res[CNT_W-1:0] = cnt + 1'b1;
        end else if (!inc_i && dec_i) begin
            res[CNT_W-1:0] = cnt - 1'b1;
        end
        return res;
    endfunction

    assign inc = pulse_in & ch_enable;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) nz[i] = (cnt_q[i] != '0);
    end

    assign pending_any = |nz;

    // Round-robin search: rotate the non-zero map so bit 0 is channel last+1,
    // then take the lowest set bit and map it back to a channel number.
    always_comb begin
        int w;
        start  = {1'b0, last_q} + 1'b1;
        nz_rot = {nz, nz} >> start;
        found  = 1'b0;
        winner = '0;
        w      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && nz_rot[k]) begin
                found = 1'b1;
                w     = int'(start) + k;
                if (w >= NUM_CH) w = w - NUM_CH;
                winner = ID_W'(w);
            end
        end
    end

    // Output FSM: EMPTY / PRESENT, reloaded whenever the output slot is free.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        load    = (state_q == EMPTY) || evt.evt_ready;
        if (load) begin
            if (found) begin
                state_d = PRESENT;
                ch_d    = winner;
                last_d  = winner;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dec[i] = load && found && (winner == ID_W'(i));
            {lost[i], cnt_d[i]} = cnt_step(cnt_q[i], inc[i], dec[i]);
            // A disabled channel is cleared; an already presented event stays.
            if (!ch_enable[i]) begin
                cnt_d[i] = '0;
                lost[i]  = 1'b0;
            end
        end
    end

    // Registered state: output slot, RR pointer, counters, drop flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ch_q       <= '0;
            last_q     <= ID_W'(NUM_CH - 1);
            drop_pulse <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            drop_pulse <= |lost;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef PULSE_ARB_OVF_STICKY_EN
    // Set has priority over clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) ovf_sticky <= '0;
        else        ovf_sticky <= lost | (ovf_sticky & ~ovf_clr);
    end
`endif

    assign evt.evt_valid = (state_q == PRESENT);
    assign evt.evt_ch    = ch_q;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Self-checking bench for pulse_event_arbiter: a directed vector table,
// hand-written multi-cycle sequences, and a randomized run, all checked
// against a behavioural model of pending counts and the output slot.
module tb_pulse_event_arbiter;
    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] pulse_in;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] ovf_clr;
    logic              pending_any;
    logic              drop_pulse;
`ifdef PULSE_ARB_OVF_STICKY_EN
    logic [NUM_CH-1:0] ovf_sticky;
`endif

    pulse_event_arbiter_if #(.ID_W(ID_W)) evt_bus ();

    pulse_event_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (pulse_in),
        .ch_enable   (ch_enable),
`ifdef PULSE_ARB_OVF_STICKY_EN
        .ovf_clr     (ovf_clr),
        .ovf_sticky  (ovf_sticky),
`endif
        .evt         (evt_bus),
        .pending_any (pending_any),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_count [NUM_CH];

    // Behavioural model state
    int m_cnt [NUM_CH];
    bit m_sticky [NUM_CH];
    bit m_valid;
    int m_ch;
    int m_last;
    bit m_drop;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i]    = 0;
            m_sticky[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_ch    = 0;
        m_last  = NUM_CH - 1;
        m_drop  = 1'b0;
    endtask

    task automatic model_step(input logic rstn, input logic [NUM_CH-1:0] p,
                              input logic [NUM_CH-1:0] en, input logic r,
                              input logic [NUM_CH-1:0] clr);
        int win;
        bit any_lost;
        bit free;
        if (!rstn) begin
            model_reset();
            return;
        end
        free = !m_valid || r;
        win  = -1;
        if (free) begin
            for (int off = 1; off <= NUM_CH; off++) begin
                int c;
                c = (m_last + off) % NUM_CH;
                if (win < 0 && m_cnt[c] > 0) win = c;
            end
        end
        any_lost = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            int nxt;
            bit lost_i;
            lost_i = 1'b0;
            if (!en[i]) begin
                nxt = 0;
            end else begin
                nxt = m_cnt[i] + (p[i] ? 1 : 0) - ((i == win) ? 1 : 0);
                if (nxt > CMAX) begin
                    nxt    = CMAX;
                    lost_i = 1'b1;
                end
            end
            m_cnt[i]    = nxt;
            m_sticky[i] = lost_i || (m_sticky[i] && !clr[i]);
            any_lost    = any_lost || lost_i;
        end
        m_drop = any_lost;
        if (free) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_ch    = win;
                m_last  = win;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    function automatic bit model_pending();
        bit any;
        any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) if (m_cnt[i] > 0) any = 1'b1;
        return any;
    endfunction

    // Drive one cycle of inputs, clock it, advance the model and compare.
    task automatic tick(input logic rstn, input logic [NUM_CH-1:0] p,
                        input logic [NUM_CH-1:0] en, input logic r,
                        input logic [NUM_CH-1:0] clr);
        logic            hs;
        logic [ID_W-1:0] hs_ch;
        rst_n             = rstn;
        pulse_in          = p;
        ch_enable         = en;
        evt_bus.evt_ready = r;
        ovf_clr           = clr;
        #1;
        hs    = evt_bus.evt_valid && r;
        hs_ch = evt_bus.evt_ch;
        @(posedge clk);
        model_step(rstn, p, en, r, clr);
        if (rstn && hs === 1'b1) hs_count[hs_ch]++;
        #1;
        chk("evt_valid", int'(evt_bus.evt_valid), int'(m_valid));
        chk("evt_ch", int'(evt_bus.evt_ch), m_ch);
        chk("pending_any", int'(pending_any), int'(model_pending()));
        chk("drop_pulse", int'(drop_pulse), int'(m_drop));
`ifdef PULSE_ARB_OVF_STICKY_EN
        for (int i = 0; i < NUM_CH; i++)
            chk("ovf_sticky", int'(ovf_sticky[i]), int'(m_sticky[i]));
`endif
    endtask

    task automatic clear_hs();
        for (int i = 0; i < NUM_CH; i++) hs_count[i] = 0;
    endtask

    typedef struct {
        logic              rstn;
        logic [NUM_CH-1:0] pulse;
        logic [NUM_CH-1:0] en;
        logic              ready;
        logic              exp_valid;
        logic [ID_W-1:0]   exp_ch;
        logic              exp_pend;
        logic              exp_drop;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int drops;
        model_reset();
        clear_hs();

        // Single pulse on ch2, then round-robin over all channels after reset.
        vecs[0]  = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'h4, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 4'h9, 4'hF, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};

        for (int v = 0; v < 18; v++) begin
            tick(vecs[v].rstn, vecs[v].pulse, vecs[v].en, vecs[v].ready, 4'h0);
            chk($sformatf("vec%0d_valid", v), int'(evt_bus.evt_valid), int'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_ch", v), int'(evt_bus.evt_ch), int'(vecs[v].exp_ch));
            chk($sformatf("vec%0d_pend", v), int'(pending_any), int'(vecs[v].exp_pend));
            chk($sformatf("vec%0d_drop", v), int'(drop_pulse), int'(vecs[v].exp_drop));
        end

        // Stall and hold: 3 pulses on ch1 with ready low, then drain.
        tick(1'b0, 4'h0, 4'hF, 1'b0, 4'h0);
        clear_hs();
        for (int k = 0; k < 3; k++) tick(1'b1, 4'h2, 4'hF, 1'b0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 4'h0, 4'hF, 1'b0, 4'h0);
            chk("stall_valid", int'(evt_bus.evt_valid), 1);
            chk("stall_ch", int'(evt_bus.evt_ch), 1);
        end
        for (int k = 0; k < 6; k++) tick(1'b1, 4'h0, 4'hF, 1'b1, 4'h0);
        chk("stall_ch1_events", hs_count[1], 3);

        // Saturation: 9 pulses on ch0 with ready low, one is lost.
        tick(1'b0, 4'h0, 4'hF, 1'b0, 4'h0);
        clear_hs();
        drops = 0;
        for (int k = 0; k < 9; k++) begin
            tick(1'b1, 4'h1, 4'hF, 1'b0, 4'h0);
            if (drop_pulse === 1'b1) drops++;
        end
        tick(1'b1, 4'h0, 4'hF, 1'b0, 4'h0);
        if (drop_pulse === 1'b1) drops++;
        chk("sat_drop_cycles", drops, 1);
`ifdef PULSE_ARB_OVF_STICKY_EN
        chk("sat_sticky0", int'(ovf_sticky[0]), 1);
`endif
        // Handshake and new pulse together at max: no loss.
        tick(1'b1, 4'h1, 4'hF, 1'b1, 4'h0);
        chk("incdec_drop", int'(drop_pulse), 0);
        for (int k = 0; k < 12; k++) tick(1'b1, 4'h0, 4'hF, 1'b1, 4'h0);
        chk("sat_ch0_events", hs_count[0], 9);
        chk("sat_pend_after", int'(pending_any), 0);

        // Disable with cnt[2]=4, then reset mid-stall.
        tick(1'b0, 4'h0, 4'hF, 1'b0, 4'h0);
        clear_hs();
        for (int k = 0; k < 5; k++) tick(1'b1, 4'h4, 4'hF, 1'b0, 4'h0);
        chk("dis_pend_before", int'(pending_any), 1);
        tick(1'b1, 4'h0, 4'hB, 1'b0, 4'h0);
        chk("dis_valid_kept", int'(evt_bus.evt_valid), 1);
        chk("dis_ch_kept", int'(evt_bus.evt_ch), 2);
        chk("dis_pend", int'(pending_any), 0);
        for (int k = 0; k < 6; k++) tick(1'b1, 4'h0, 4'hF, 1'b1, 4'h0);
        chk("dis_ch2_events", hs_count[2], 1);
        for (int k = 0; k < 3; k++) tick(1'b1, 4'h2, 4'hF, 1'b0, 4'h0);
        tick(1'b0, 4'h0, 4'hF, 1'b0, 4'h0);
        chk("rst_mid_valid", int'(evt_bus.evt_valid), 0);
        chk("rst_mid_pend", int'(pending_any), 0);

        // Randomized run against the model.
        for (int k = 0; k < 3000; k++) begin
            logic              rr;
            logic [NUM_CH-1:0] pp, ee, cc;
            rr = ($urandom_range(0, 3) != 0);
            if (k % 200 < 40) rr = 1'b0;
            pp = NUM_CH'($urandom);
            ee = ($urandom_range(0, 19) == 0) ? NUM_CH'($urandom) : '1;
            cc = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
            tick(($urandom_range(0, 299) != 0), pp, ee, rr, cc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
